// File: rtl/dest_scoreboard.sv
// dest_scoreboard: pending-write scoreboard raising ID-stage RAW stalls.
// Define SB_STALL_STATS_EN to add a saturating stall-cycle counter.
module dest_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_forward,
  input  logic                single_source,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                issue_is_load,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic                Hazard_Detected,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sb_error,
  output logic [15:0]         stall_count
);

  localparam int EXT = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_nxt;
  logic                           err_set;
  logic                           ld_valid;
  logic [ADDR_W-1:0]              ld_dest;
  logic [EXT-1:0]                 busy_ext;
  logic                           match1;
  logic                           match2;
  logic                           issue_fire;
  logic                           wb_fire;

  // A register is busy while its pending counter is nonzero; r0 never is.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = |cnt[i];
    end
  end

  // Widen so any ADDR_W index is safe even when NUM_REGS < 2**ADDR_W.
  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_vec;
  end

  // Stall decision depends only on state and the ID-stage sources.
  always_comb begin
    if (is_forward) begin
      match1 = ld_valid && (src1 != '0) && (ld_dest == src1);
      match2 = ld_valid && (src2 != '0) && (ld_dest == src2);
    end else begin
      match1 = (src1 != '0) && busy_ext[src1];
      match2 = (src2 != '0) && busy_ext[src2];
    end
    Hazard_Detected = match1 || (!single_source && match2);
  end

  assign issue_fire = issue_valid && issue_wb_en &&
                      !Hazard_Detected && (issue_dest != '0);
  assign wb_fire    = wb_valid && (wb_dest != '0);

  // Per-register next count; overflow/underflow hold the count and flag.
  always_comb begin
    cnt_nxt = cnt;
    err_set = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_fire && issue_dest == ADDR_W'(i) &&
          !(wb_fire && wb_dest == ADDR_W'(i))) begin
        if (cnt[i] == CNT_MAX) err_set = 1'b1;
        else cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (wb_fire && wb_dest == ADDR_W'(i) &&
                   !(issue_fire && issue_dest == ADDR_W'(i))) begin
        if (cnt[i] == '0) err_set = 1'b1;
        else cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Counter state and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sb_error <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (err_set) sb_error <= 1'b1;
    end
  end

  // Track the load currently in EXE; it leaves after one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid <= 1'b0;
      ld_dest  <= '0;
    end else begin
      ld_valid <= issue_fire && issue_is_load;
      if (issue_fire && issue_is_load) ld_dest <= issue_dest;
    end
  end

`ifdef SB_STALL_STATS_EN
  // Count cycles where an issue attempt is held back, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (Hazard_Detected && issue_valid &&
                 stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard: scoreboard bench for dest_scoreboard.
// Expected outputs are queued per driven cycle and popped after the edge.
module tb_dest_scoreboard;

  typedef struct packed {
    logic [31:0] busy;
    logic        hz;
    logic        err;
    logic [15:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_forward;
  logic        single_source;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [4:0]  issue_dest;
  logic        issue_is_load;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic        Hazard_Detected;
  logic [31:0] busy_vec;
  logic        sb_error;
  logic [15:0] stall_count;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];
  exp_t e;

  int   mcnt[32];
  bit   merr;
  bit   mld_v;
  int   mld_d;
  int   mstall;
`ifdef SB_STALL_STATS_EN
  bit   stat_en = 1'b1;
`else
  bit   stat_en = 1'b0;
`endif

  dest_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .is_forward(is_forward),
    .single_source(single_source),
    .src1(src1),
    .src2(src2),
    .issue_valid(issue_valid),
    .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest),
    .issue_is_load(issue_is_load),
    .wb_valid(wb_valid),
    .wb_dest(wb_dest),
    .Hazard_Detected(Hazard_Detected),
    .busy_vec(busy_vec),
    .sb_error(sb_error),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic bit mhaz();
    bit h1, h2;
    if (is_forward) begin
      h1 = src1 != 0 && mld_v && mld_d == int'(src1);
      h2 = src2 != 0 && mld_v && mld_d == int'(src2);
    end else begin
      h1 = src1 != 0 && mcnt[src1] > 0;
      h2 = src2 != 0 && mcnt[src2] > 0;
    end
    return h1 || (!single_source && h2);
  endfunction

  task automatic model_clear();
    foreach (mcnt[i]) mcnt[i] = 0;
    merr = 0; mld_v = 0; mld_d = 0; mstall = 0;
    sbq.delete();
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
    issue_is_load = 0; wb_valid = 0; wb_dest = 0;
    src1 = 0; src2 = 0; single_source = 1; is_forward = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  // Predict the post-edge outputs, queue them, then clock once.
  task automatic step();
    exp_t x;
    bit hz, ifire, wfire;
    hz = mhaz();
    ifire = issue_valid && issue_wb_en && !hz && issue_dest != 0;
    wfire = wb_valid && wb_dest != 0;
    if (hz && issue_valid && mstall < 65535) mstall++;
    if (ifire && !(wfire && wb_dest == issue_dest)) begin
      if (mcnt[issue_dest] == 3) merr = 1;
      else mcnt[issue_dest]++;
    end
    if (wfire && !(ifire && issue_dest == wb_dest)) begin
      if (mcnt[wb_dest] == 0) merr = 1;
      else mcnt[wb_dest]--;
    end
    mld_v = ifire && issue_is_load;
    if (mld_v) mld_d = int'(issue_dest);
    x.busy = '0;
    for (int i = 1; i < 32; i++) x.busy[i] = mcnt[i] > 0;
    x.hz = mhaz();
    x.err = merr;
    x.stall = stat_en ? 16'(mstall) : 16'd0;
    sbq.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #1;
    vectors++;
    if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== 50'd0) begin
      miscompares++;
      $display("FAIL reset busy=%h hz=%b err=%b st=%0d want all 0",
               busy_vec, Hazard_Detected, sb_error, stall_count);
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_raw_stall();
    idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 5;
    step();
    e = sbq.pop_front(); vectors++;
    if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL raw_issue got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    idle(); src1 = 5; #1;
    vectors++;
    if (Hazard_Detected !== 1'b1 || busy_vec[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_hazard hz=%b busy5=%b want 1 1",
               Hazard_Detected, busy_vec[5]);
    end
    issue_valid = 1; issue_wb_en = 1; issue_dest = 7;
    for (int k = 0; k < 2; k++) begin
      step();
      e = sbq.pop_front(); vectors++;
      if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
        miscompares++;
        $display("FAIL raw_held got %h want %h",
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    wb_valid = 1; wb_dest = 5; #1;
    vectors++;
    if (Hazard_Detected !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_same_cycle_retire hz=%b want 1", Hazard_Detected);
    end
    step();
    e = sbq.pop_front(); vectors++;
    if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL raw_retire got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    idle(); #1;
    vectors++;
    if (busy_vec !== 32'd0 || Hazard_Detected !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_clear busy=%h hz=%b want 0 0",
               busy_vec, Hazard_Detected);
    end
  endtask

  task automatic test_back_to_back();
    idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 5;
    step(); step();
    idle(); wb_valid = 1; wb_dest = 5;
    step();
    for (int k = 0; k < 3; k++) begin
      e = sbq.pop_front(); vectors++;
      if (k == 2 && busy_vec[5] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_one_left busy5=%b want 1", busy_vec[5]);
      end
      if (k == 2 && {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
        miscompares++;
        $display("FAIL b2b_state got %h want %h",
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    step();
    e = sbq.pop_front(); vectors++;
    if (busy_vec[5] !== 1'b0 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL b2b_drained got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    idle();
  endtask

  task automatic test_load_use();
    idle(); is_forward = 1;
    issue_valid = 1; issue_wb_en = 1; issue_is_load = 1; issue_dest = 8;
    step();
    e = sbq.pop_front(); vectors++;
    if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL ld_issue got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    issue_is_load = 0; issue_dest = 10;
    src1 = 2; src2 = 8; single_source = 0; #1;
    vectors++;
    if (Hazard_Detected !== 1'b1) begin
      miscompares++;
      $display("FAIL ld_use_stall hz=%b want 1", Hazard_Detected);
    end
    step();
    e = sbq.pop_front(); vectors++;
    if (Hazard_Detected !== 1'b0 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL ld_one_cycle got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    step();
    e = sbq.pop_front(); vectors++;
    if (busy_vec[10] !== 1'b1 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL ld_consumer got %h want %h",
               {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
    end
    idle(); is_forward = 1; src1 = 10; #1;
    vectors++;
    if (Hazard_Detected !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_no_stall hz=%b want 0", Hazard_Detected);
    end
    is_forward = 0; #1;
    vectors++;
    if (Hazard_Detected !== 1'b1) begin
      miscompares++;
      $display("FAIL nofwd_stall hz=%b want 1", Hazard_Detected);
    end
    idle(); wb_valid = 1; wb_dest = 8; step();
    wb_dest = 10; step();
    for (int k = 0; k < 2; k++) begin
      e = sbq.pop_front(); vectors++;
      if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e && k == 1) begin
        miscompares++;
        $display("FAIL ld_cleanup got %h want %h",
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    idle();
  endtask

  task automatic test_reg_zero();
    idle(); is_forward = 1; single_source = 0;
    issue_valid = 1; issue_wb_en = 1; issue_is_load = 1; issue_dest = 0;
    step();
    e = sbq.pop_front(); vectors++;
    if (busy_vec !== 32'd0 || Hazard_Detected !== 1'b0 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL r0_fwd busy=%h hz=%b want 0 0", busy_vec, Hazard_Detected);
    end
    is_forward = 0; #1;
    vectors++;
    if (Hazard_Detected !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_nofwd hz=%b want 0", Hazard_Detected);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 3;
    step();
    wb_valid = 1; wb_dest = 3;
    step();
    void'(sbq.pop_front());
    e = sbq.pop_front(); vectors++;
    if (busy_vec[3] !== 1'b1 || sb_error !== 1'b0 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL same_cycle busy3=%b err=%b want 1 0", busy_vec[3], sb_error);
    end
    idle(); wb_valid = 1; wb_dest = 3;
    step();
    e = sbq.pop_front(); vectors++;
    if (busy_vec[3] !== 1'b0 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL same_cycle_drain busy3=%b want 0", busy_vec[3]);
    end
    idle();
  endtask

  task automatic test_underflow_reset();
    idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 4;
    step();
    idle(); wb_valid = 1; wb_dest = 9;
    step();
    void'(sbq.pop_front());
    e = sbq.pop_front(); vectors++;
    if (sb_error !== 1'b1 || {busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
      miscompares++;
      $display("FAIL underflow err=%b want 1", sb_error);
    end
    idle();
    step(); step();
    void'(sbq.pop_front());
    e = sbq.pop_front(); vectors++;
    if (sb_error !== 1'b1 || busy_vec[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky err=%b busy4=%b want 1 1", sb_error, busy_vec[4]);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (busy_vec !== 32'd0 || sb_error !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset busy=%h err=%b want 0 0", busy_vec, sb_error);
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_overflow();
    idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 6;
    for (int k = 0; k < 4; k++) begin
      step();
      e = sbq.pop_front(); vectors++;
      if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
        miscompares++;
        $display("FAIL overflow_issue%0d got %h want %h", k,
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    vectors++;
    if (sb_error !== 1'b1 || busy_vec[6] !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow err=%b busy6=%b want 1 1", sb_error, busy_vec[6]);
    end
    idle(); wb_valid = 1; wb_dest = 6;
    for (int k = 0; k < 3; k++) begin
      step();
      e = sbq.pop_front(); vectors++;
      if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
        miscompares++;
        $display("FAIL overflow_retire%0d got %h want %h", k,
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    vectors++;
    if (busy_vec[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_drain busy6=%b want 0", busy_vec[6]);
    end
    idle();
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      is_forward    = ($urandom_range(0, 3) == 0);
      single_source = $urandom_range(0, 1);
      src1          = 5'($urandom_range(0, 7));
      src2          = 5'($urandom_range(0, 7));
      issue_valid   = $urandom_range(0, 1);
      issue_wb_en   = ($urandom_range(0, 3) != 0);
      issue_is_load = $urandom_range(0, 1);
      issue_dest    = 5'($urandom_range(0, 7));
      wb_valid      = $urandom_range(0, 1);
      wb_dest       = 5'($urandom_range(0, 7));
      step();
      e = sbq.pop_front(); vectors++;
      if ({busy_vec, Hazard_Detected, sb_error, stall_count} !== e) begin
        miscompares++;
        $display("FAIL random%0d got %h want %h", n,
                 {busy_vec, Hazard_Detected, sb_error, stall_count}, e);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_back_to_back();
    test_load_use();
    test_reg_zero();
    test_same_cycle();
    test_underflow_reset();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
